// File: rtl/tick_counter_leds.sv
// tick_counter_leds: prescaled LED counter.
// A free-running prescaler produces a tick every SLEEP_TICKS enabled clocks;
// each tick steps COUNT up or down, wrapping or saturating at the range ends.
// Optional feature: define TICK_COUNTER_GRAY_EN to add a registered GRAY
// output that always carries the Gray code of COUNT.
module tick_counter_leds #(
  parameter int          WIDTH       = 8,
  parameter int          TICK_W      = 32,
  parameter int unsigned SLEEP_TICKS = 100000000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIR,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TICK,
  output logic             WRAP
`ifdef TICK_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] GRAY
`endif
);

  // Last prescaler value of a period; reaching it while enabled is a tick.
  localparam logic [TICK_W-1:0] PRESCALE_LAST = TICK_W'(SLEEP_TICKS - 1);
  localparam logic [WIDTH-1:0]  COUNT_MAX     = '1;

  logic [TICK_W-1:0] prescale;
  logic              tick_edge;
  logic [WIDTH-1:0]  count_step;
  logic              wrap_step;
  logic [WIDTH-1:0]  count_d;

  assign tick_edge = EN && (prescale == PRESCALE_LAST);

  // Value COUNT would take on a tick edge, and whether that step wraps.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_step = COUNT;
    wrap_step  = 1'b0;
    if (!DIR) begin
      if (COUNT == COUNT_MAX) begin
        if (!SAT) begin
          count_step = '0;
          wrap_step  = 1'b1;
        end
      end else begin
        count_step = COUNT + WIDTH'(1);
      end
    end else begin
      if (COUNT == '0) begin
        if (!SAT) begin
          count_step = COUNT_MAX;
          wrap_step  = 1'b1;
        end
      end else begin
        count_step = COUNT - WIDTH'(1);
      end
    end
  end

  // Next COUNT for a non-reset edge: load beats a tick, otherwise hold.
  always_comb begin
    count_d = COUNT;
    if (LOAD) begin
      count_d = LOAD_VAL;
    end else if (tick_edge) begin
      count_d = count_step;
    end
  end

  // Prescaler, count and pulse registers; reset > LOAD > EN.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!RST_N) begin
      prescale <= '0;
      COUNT    <= '0;
      TICK     <= 1'b0;
      WRAP     <= 1'b0;
    end else if (LOAD) begin
      prescale <= '0;
      COUNT    <= count_d;
      TICK     <= 1'b0;
      WRAP     <= 1'b0;
    end else begin
      if (EN) begin
        prescale <= tick_edge ? '0 : prescale + TICK_W'(1);
      end
      COUNT <= count_d;
      TICK  <= tick_edge;
      WRAP  <= tick_edge && wrap_step;
    end
  end

`ifdef TICK_COUNTER_GRAY_EN
  // Gray code registered from the same next value as COUNT, so they never skew.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      GRAY <= '0;
    end else begin
      GRAY <= count_d ^ (count_d >> 1);
    end
  end
`endif

endmodule
